// File: rtl/rs_pkg.sv
// Shared definitions for the RS(204,188) decode sequencer: parameter defaults,
// state encoding and a saturating counter helper.
package rs_pkg;

  localparam int N_BYTES_DEF = 204;
  localparam int T_MAX_DEF   = 8;
  localparam int TIMEOUT_DEF = 1023;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    SYND_WAIT,
    ELC_WAIT,
    CHIEN_WAIT,
    OUTPUT
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rs_decode_sequencer_if.sv
// Handshake bundle between the decode sequencer and the RS datapath blocks.
interface rs_decode_sequencer_if;

  logic        in_valid;
  logic        in_sop;
  logic        in_ready;
  logic        synd_start;
  logic        synd_done;
  logic        synd_zero;
  logic        elc_start;
  logic        elc_done;
  logic [3:0]  elc_degree;
  logic        chien_start;
  logic        chien_done;
  logic [3:0]  chien_roots;
  logic        out_start;
  logic        out_correct;
  logic        out_done;
  logic        busy;
  logic        fail;
  logic [15:0] blk_count;
  logic [15:0] fail_count;

  // master is the datapath/environment side, slave is the sequencer
  modport master (
    output in_valid, in_sop, synd_done, synd_zero, elc_done, elc_degree,
           chien_done, chien_roots, out_done,
    input  in_ready, synd_start, elc_start, chien_start, out_start,
           out_correct, busy, fail, blk_count, fail_count
  );

  modport slave (
    input  in_valid, in_sop, synd_done, synd_zero, elc_done, elc_degree,
           chien_done, chien_roots, out_done,
    output in_ready, synd_start, elc_start, chien_start, out_start,
           out_correct, busy, fail, blk_count, fail_count
  );

endinterface

// File: rtl/rs_watchdog.sv
// Wait-state watchdog: 10-bit cycle counter that flags expiry once LIMIT
// cycles have been spent in the same wait state.
module rs_watchdog #(
  parameter int unsigned LIMIT = rs_pkg::TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [9:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 10'd0;
    end else if (clear) begin
      count <= 10'd0;
    end else if (enable) begin
      count <= count + 10'd1;
    end
  end

  // count reads k in the k-th cycle (from 0) of a state, so LIMIT-1 ends the LIMIT-th cycle
  assign expire = enable && (count == 10'(LIMIT - 1));

endmodule

// File: rtl/rs_decode_sequencer.sv
// Control sequencer for an RS(204,188) decoder: receives a codeword, then steps
// syndrome, Berlekamp-Massey, Chien/Forney and readout with registered strobes.
module rs_decode_sequencer
  import rs_pkg::*;
#(
  parameter int          N_BYTES = N_BYTES_DEF,
  parameter int          T_MAX   = T_MAX_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  rs_decode_sequencer_if.slave bus
);

  state_t     state, state_n;
  logic [7:0] byte_cnt, byte_cnt_n;
  logic [3:0] degree, degree_n;
  logic       synd_start_n, elc_start_n, chien_start_n, out_start_n;
  logic       correct_n, fail_n, blk_inc;
  logic       in_wait, wd_clear, wd_expire;

  rs_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (in_wait),
    .expire (wd_expire)
  );

  assign bus.in_ready = (state == IDLE) || (state == RECV);
  assign bus.busy     = (state != IDLE);

  always_comb begin
    in_wait  = (state == SYND_WAIT) || (state == ELC_WAIT) ||
               (state == CHIEN_WAIT) || (state == OUTPUT);
    wd_clear = !in_wait || (state_n != state);
  end

  always_comb begin
    state_n       = state;
    byte_cnt_n    = byte_cnt;
    degree_n      = degree;
    correct_n     = bus.out_correct;
    synd_start_n  = 1'b0;
    elc_start_n   = 1'b0;
    chien_start_n = 1'b0;
    out_start_n   = 1'b0;
    fail_n        = 1'b0;
    blk_inc       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid && bus.in_sop) begin
          synd_start_n = 1'b1;
          byte_cnt_n   = 8'd1;
          state_n      = RECV;
        end
      end
      RECV: begin
        if (bus.in_valid && bus.in_sop) begin
          // a new start-of-packet inside a frame abandons the old one and restarts
          fail_n       = 1'b1;
          synd_start_n = 1'b1;
          byte_cnt_n   = 8'd1;
        end else if (bus.in_valid) begin
          byte_cnt_n = byte_cnt + 8'd1;
          if (byte_cnt == 8'(N_BYTES - 1)) state_n = SYND_WAIT;
        end
      end
      SYND_WAIT: begin
        if (bus.synd_done) begin
          if (bus.synd_zero) begin
            out_start_n = 1'b1;
            correct_n   = 1'b0;
            state_n     = OUTPUT;
          end else begin
            elc_start_n = 1'b1;
            state_n     = ELC_WAIT;
          end
        end else if (wd_expire) begin
          fail_n  = 1'b1;
          state_n = IDLE;
        end
      end
      ELC_WAIT: begin
        if (bus.elc_done) begin
          if (bus.elc_degree > 4'(T_MAX)) begin
            fail_n      = 1'b1;
            out_start_n = 1'b1;
            correct_n   = 1'b0;
            state_n     = OUTPUT;
          end else begin
            degree_n      = bus.elc_degree;
            chien_start_n = 1'b1;
            state_n       = CHIEN_WAIT;
          end
        end else if (wd_expire) begin
          fail_n  = 1'b1;
          state_n = IDLE;
        end
      end
      CHIEN_WAIT: begin
        if (bus.chien_done) begin
          correct_n   = (bus.chien_roots == degree);
          fail_n      = (bus.chien_roots != degree);
          out_start_n = 1'b1;
          state_n     = OUTPUT;
        end else if (wd_expire) begin
          fail_n  = 1'b1;
          state_n = IDLE;
        end
      end
      OUTPUT: begin
        if (bus.out_done) begin
          blk_inc   = 1'b1;
          correct_n = 1'b0;
          state_n   = IDLE;
        end else if (wd_expire) begin
          fail_n    = 1'b1;
          correct_n = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      byte_cnt        <= 8'd0;
      degree          <= 4'd0;
      bus.synd_start  <= 1'b0;
      bus.elc_start   <= 1'b0;
      bus.chien_start <= 1'b0;
      bus.out_start   <= 1'b0;
      bus.out_correct <= 1'b0;
      bus.fail        <= 1'b0;
      bus.blk_count   <= 16'd0;
      bus.fail_count  <= 16'd0;
    end else begin
      state           <= state_n;
      byte_cnt        <= byte_cnt_n;
      degree          <= degree_n;
      bus.synd_start  <= synd_start_n;
      bus.elc_start   <= elc_start_n;
      bus.chien_start <= chien_start_n;
      bus.out_start   <= out_start_n;
      bus.out_correct <= correct_n;
      bus.fail        <= fail_n;
      if (blk_inc) bus.blk_count <= sat_inc(bus.blk_count);
      if (fail_n) bus.fail_count <= sat_inc(bus.fail_count);
    end
  end

endmodule

// File: tb/tb_rs_decode_sequencer.sv
// Self-checking bench for rs_decode_sequencer: directed frames with a
// per-cycle expectation model and literal checkpoints.
module tb_rs_decode_sequencer;

  localparam int NB   = 204;
  localparam int TMAX = 8;
  localparam int TO   = 1023;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rs_decode_sequencer_if bus();

  rs_decode_sequencer #(.N_BYTES(NB), .T_MAX(TMAX), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // exp_* is what the outputs must show this cycle; nx_* what they must show next cycle
  logic exp_in_ready, exp_busy, exp_synd, exp_elc, exp_chien, exp_out, exp_corr, exp_fail;
  logic nx_in_ready, nx_busy, nx_synd, nx_elc, nx_chien, nx_out, nx_corr, nx_fail;
  logic [15:0] exp_blk, exp_fcnt, nx_blk, nx_fcnt;
  logic [3:0] m_deg;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("in_ready",    {15'd0, bus.in_ready},    {15'd0, exp_in_ready});
      cmp("busy",        {15'd0, bus.busy},        {15'd0, exp_busy});
      cmp("synd_start",  {15'd0, bus.synd_start},  {15'd0, exp_synd});
      cmp("elc_start",   {15'd0, bus.elc_start},   {15'd0, exp_elc});
      cmp("chien_start", {15'd0, bus.chien_start}, {15'd0, exp_chien});
      cmp("out_start",   {15'd0, bus.out_start},   {15'd0, exp_out});
      cmp("out_correct", {15'd0, bus.out_correct}, {15'd0, exp_corr});
      cmp("fail",        {15'd0, bus.fail},        {15'd0, exp_fail});
      cmp("blk_count",   bus.blk_count,            exp_blk);
      cmp("fail_count",  bus.fail_count,           exp_fcnt);
    end
  end

  task automatic reset_model();
    exp_in_ready = 1'b1; exp_busy = 1'b0; exp_synd = 1'b0; exp_elc = 1'b0;
    exp_chien = 1'b0; exp_out = 1'b0; exp_corr = 1'b0; exp_fail = 1'b0;
    exp_blk = 16'd0; exp_fcnt = 16'd0;
    nx_in_ready = 1'b1; nx_busy = 1'b0; nx_synd = 1'b0; nx_elc = 1'b0;
    nx_chien = 1'b0; nx_out = 1'b0; nx_corr = 1'b0; nx_fail = 1'b0;
    nx_blk = 16'd0; nx_fcnt = 16'd0;
    m_deg = 4'd0;
  endtask

  task automatic clear_inputs();
    bus.in_valid = 1'b0; bus.in_sop = 1'b0;
    bus.synd_done = 1'b0; bus.synd_zero = 1'b0;
    bus.elc_done = 1'b0; bus.elc_degree = 4'd0;
    bus.chien_done = 1'b0; bus.chien_roots = 4'd0;
    bus.out_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    exp_synd = nx_synd;   nx_synd = 1'b0;
    exp_elc = nx_elc;     nx_elc = 1'b0;
    exp_chien = nx_chien; nx_chien = 1'b0;
    exp_out = nx_out;     nx_out = 1'b0;
    exp_fail = nx_fail;   nx_fail = 1'b0;
    exp_in_ready = nx_in_ready;
    exp_busy = nx_busy;
    exp_corr = nx_corr;
    exp_blk = nx_blk;
    exp_fcnt = nx_fcnt;
    clear_inputs();
  endtask

  task automatic expect_fail();
    nx_fail = 1'b1;
    if (nx_fcnt != 16'hFFFF) nx_fcnt = nx_fcnt + 16'd1;
  endtask

  // spur = {synd, elc, chien, out}: done strobes that the current state must ignore
  task automatic applyStimulus(input int n, input logic [3:0] spur);
    for (int i = 0; i < n; i++) begin
      bus.synd_done   = spur[3];
      bus.synd_zero   = spur[3];
      bus.elc_done    = spur[2];
      bus.elc_degree  = 4'd15;
      bus.chien_done  = spur[1];
      bus.chien_roots = 4'd7;
      bus.out_done    = spur[0];
      tick();
    end
  endtask

  task automatic send_frame(input int restart_at);
    int got;
    bit restarted;
    bus.in_valid = 1'b1; bus.in_sop = 1'b1;
    nx_synd = 1'b1; nx_busy = 1'b1; nx_in_ready = 1'b1;
    tick();
    got = 1;
    restarted = 1'b0;
    while (got < NB) begin
      bus.in_valid = 1'b1;
      if (restart_at > 0 && !restarted && got == restart_at - 1) begin
        bus.in_sop = 1'b1;
        nx_synd = 1'b1;
        expect_fail();
        got = 1;
        restarted = 1'b1;
      end else begin
        got++;
      end
      if (got == NB) nx_in_ready = 1'b0;
      tick();
      if (got % 64 == 0 && got < NB) tick();
    end
  endtask

  task automatic synd(input bit zero);
    bus.synd_done = 1'b1; bus.synd_zero = zero;
    if (zero) begin
      nx_out = 1'b1; nx_corr = 1'b0;
    end else begin
      nx_elc = 1'b1;
    end
    tick();
  endtask

  task automatic elc(input int deg);
    bus.elc_done = 1'b1; bus.elc_degree = 4'(deg);
    if (deg > TMAX) begin
      expect_fail(); nx_out = 1'b1; nx_corr = 1'b0;
    end else begin
      m_deg = 4'(deg); nx_chien = 1'b1;
    end
    tick();
  endtask

  task automatic chien(input int roots);
    bus.chien_done = 1'b1; bus.chien_roots = 4'(roots);
    nx_corr = (4'(roots) == m_deg);
    if (!nx_corr) expect_fail();
    nx_out = 1'b1;
    tick();
  endtask

  task automatic finish_out();
    bus.out_done = 1'b1;
    if (nx_blk != 16'hFFFF) nx_blk = nx_blk + 16'd1;
    nx_corr = 1'b0; nx_in_ready = 1'b1; nx_busy = 1'b0;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] want);
    cmp(name, act, want);
  endtask

  initial begin
    reset_model();
    clear_inputs();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_in_ready", {15'd0, bus.in_ready}, 16'd1);
    checkOutput("reset_blk", bus.blk_count, 16'd0);

    // stray byte without start-of-packet, stray done strobes in IDLE
    bus.in_valid = 1'b1;
    tick();
    applyStimulus(2, 4'b1111);

    // error-free frame
    send_frame(0);
    applyStimulus(2, 4'b0111);
    synd(1'b1);
    checkOutput("clean_out_start", {15'd0, bus.out_start}, 16'd1);
    applyStimulus(3, 4'b1110);
    finish_out();
    checkOutput("clean_blk", bus.blk_count, 16'd1);
    checkOutput("clean_fcnt", bus.fail_count, 16'd0);

    // correctable frame, degree 5 with 5 roots
    send_frame(0);
    synd(1'b0);
    applyStimulus(2, 4'b1011);
    elc(5);
    applyStimulus(2, 4'b1101);
    chien(5);
    checkOutput("corr_out_correct", {15'd0, bus.out_correct}, 16'd1);
    applyStimulus(1, 4'b1110);
    finish_out();
    checkOutput("corr_fcnt", bus.fail_count, 16'd0);

    // root count mismatch
    send_frame(0);
    synd(1'b0);
    elc(4);
    chien(3);
    checkOutput("mism_fail", {15'd0, bus.fail}, 16'd1);
    finish_out();
    checkOutput("mism_blk", bus.blk_count, 16'd3);
    checkOutput("mism_fcnt", bus.fail_count, 16'd1);

    // degree beyond correction capability
    send_frame(0);
    synd(1'b0);
    elc(9);
    checkOutput("deg9_out_correct", {15'd0, bus.out_correct}, 16'd0);
    applyStimulus(2, 4'b1110);
    finish_out();
    checkOutput("deg9_fcnt", bus.fail_count, 16'd2);

    // start-of-packet at byte 100 restarts reception
    send_frame(100);
    synd(1'b1);
    finish_out();
    checkOutput("restart_blk", bus.blk_count, 16'd5);
    checkOutput("restart_fcnt", bus.fail_count, 16'd3);

    // error locator never answers
    send_frame(0);
    synd(1'b0);
    applyStimulus(TO - 1, 4'b0000);
    expect_fail();
    nx_in_ready = 1'b1; nx_busy = 1'b0;
    tick();
    checkOutput("wd_fail", {15'd0, bus.fail}, 16'd1);
    checkOutput("wd_blk", bus.blk_count, 16'd5);
    applyStimulus(2, 4'b1111);

    // reset in the middle of a frame
    bus.in_valid = 1'b1; bus.in_sop = 1'b1;
    nx_synd = 1'b1; nx_busy = 1'b1; nx_in_ready = 1'b1;
    tick();
    for (int i = 0; i < 50; i++) begin
      bus.in_valid = 1'b1;
      tick();
    end
    #2 rst = 1'b1;
    reset_model();
    clear_inputs();
    #1;
    checkOutput("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
    checkOutput("rst_fcnt", bus.fail_count, 16'd0);
    checkOutput("rst_fail", {15'd0, bus.fail}, 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    send_frame(0);
    synd(1'b1);
    finish_out();
    checkOutput("post_rst_blk", bus.blk_count, 16'd1);

    applyStimulus(2, 4'b0000);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "[TB] run aborted");
  end

endmodule

// File: doc/rs_decode_sequencer.md
RS_DECODE_SEQUENCER -- requirements
Module: rs_decode_sequencer

Interface
REQ-001 SHALL have parameter N_BYTES, default 204, meaning bytes per RS(204,188) codeword.
REQ-002 SHALL have parameter T_MAX, default 8, meaning maximum correctable symbol errors.
REQ-003 SHALL have parameter TIMEOUT, default 1023, meaning the cycle limit for any single wait state.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Clk  in  1  sole clock, rising edge.
REQ-006 Reset  in  1  asynchronous active-high reset.
REQ-007 In_Valid  in  1  input byte strobe.
REQ-008 In_Sop  in  1  first byte of codeword, qualified by In_Valid.
REQ-009 In_Ready  out  1  sequencer accepts bytes.
REQ-010 Synd_Start  out  1  one-cycle pulse that clears and starts the syndrome calculator.
REQ-011 Synd_Done  in  1  syndromes valid.
REQ-012 Synd_Zero  in  1  all 16 syndromes zero, qualified by Synd_Done.
REQ-013 Elc_Start  out  1  one-cycle pulse that starts the error-locator (Berlekamp-Massey) unit.
REQ-014 Elc_Done  in  1  sigma coefficients valid.
REQ-015 Elc_Degree  in  4  locator degree L.
REQ-016 Chien_Start  out  1  one-cycle pulse that starts Chien search / Forney.
REQ-017 Chien_Done  in  1  root search complete.
REQ-018 Chien_Roots  in  4  number of roots found.
REQ-019 Out_Start  out  1  one-cycle pulse that starts codeword readout from the delay buffer.
REQ-020 Out_Correct  out  1  level; apply error values during readout.
REQ-021 Out_Done  in  1  readout finished.
REQ-022 Busy  out  1  high in every state except IDLE.
REQ-023 Fail  out  1  one-cycle pulse: uncorrectable, timeout or framing error.
REQ-024 Blk_Count  out  16  codewords completed, saturating at 16'hFFFF.
REQ-025 Fail_Count  out  16  Fail pulses issued, saturating at 16'hFFFF.

Function
REQ-026 FSM states SHALL be IDLE, RECV, SYND_WAIT, ELC_WAIT, CHIEN_WAIT, OUTPUT.
REQ-027 IDLE: In_Ready=1; In_Valid&In_Sop SHALL assert Synd_Start in the same cycle, load byte count 1 and go to RECV; In_Valid without In_Sop SHALL be dropped silently.
REQ-028 RECV: In_Ready=1; each In_Valid SHALL increment the 8-bit byte count; acceptance of byte N_BYTES SHALL go to SYND_WAIT with In_Ready=0 from the next cycle.
REQ-029 In_Valid&In_Sop in RECV SHALL pulse Fail, re-pulse Synd_Start, reload count 1 and stay in RECV (restart on the new frame).
REQ-030 SYND_WAIT: Synd_Done&Synd_Zero SHALL go to OUTPUT with Out_Correct=0; Synd_Done&!Synd_Zero SHALL go to ELC_WAIT; Elc_Start SHALL pulse on the transition cycle.
REQ-031 ELC_WAIT: on Elc_Done, Elc_Degree>T_MAX SHALL pulse Fail and go to OUTPUT with Out_Correct=0; otherwise SHALL latch the degree, pulse Chien_Start and go to CHIEN_WAIT.
REQ-032 CHIEN_WAIT: on Chien_Done, Out_Correct SHALL be set to (Chien_Roots==latched degree); on mismatch SHALL pulse Fail; SHALL go to OUTPUT.
REQ-033 Out_Start SHALL pulse in the cycle of entry into OUTPUT; Out_Correct SHALL hold until leaving OUTPUT.
REQ-034 OUTPUT: Out_Done SHALL increment Blk_Count, clear Out_Correct and go to IDLE (In_Ready=1 the next cycle).
REQ-035 A watchdog SHALL count cycles in SYND_WAIT, ELC_WAIT, CHIEN_WAIT and OUTPUT, clearing on each state change; reaching TIMEOUT SHALL pulse Fail and go to IDLE without Out_Start and without incrementing Blk_Count.
REQ-036 Done inputs SHALL be ignored outside their own wait state.
REQ-037 Fail SHALL be at most one pulse per cycle; Fail_Count SHALL increment on every Fail pulse.
REQ-038 Start pulses SHALL be exactly one cycle wide and registered; no output SHALL depend combinationally on any input except In_Ready, which depends on state only.

Reset
REQ-039 Reset SHALL force IDLE, byte count 0, watchdog 0, latched degree 0, Blk_Count=0, Fail_Count=0, and all outputs 0 except In_Ready=1.
REQ-040 Reset asserted mid-frame SHALL abandon the codeword without a Fail pulse; the first edge after deassertion SHALL behave as IDLE.

Structure
REQ-041 N_BYTES, T_MAX, TIMEOUT defaults and the state encoding SHALL live in shared package rs_pkg.
REQ-042 The watchdog SHALL be the sub-module rs_watchdog (10-bit counter, clear/enable inputs, expire output).

Verification
REQ-043 Error-free frame: 204 bytes, Synd_Done&Synd_Zero 3 cycles later -> no Elc_Start; Out_Start with Out_Correct=0; Out_Done -> Blk_Count=1, Fail=0.
REQ-044 Correctable frame: Synd_Zero=0, Elc_Degree=5, Chien_Roots=5 -> Elc_Start and Chien_Start one pulse each; Out_Correct=1; Fail_Count=0.
REQ-045 Root mismatch: Elc_Degree=4, Chien_Roots=3 -> Fail pulse; Out_Correct=0; Blk_Count increments; Fail_Count=1.
REQ-046 Degree 9 -> Fail pulse; no Chien_Start; Out_Start with Out_Correct=0.
REQ-047 In_Sop at byte 100 -> Fail pulse and second Synd_Start; SYND_WAIT is reached only after 204 further bytes.
REQ-048 Elc_Done withheld -> Fail pulse exactly 1023 cycles after entry into ELC_WAIT; IDLE the next cycle; Blk_Count unchanged; Reset during RECV -> In_Ready=1, counters 0.
